// File: rtl/alu_pkg.sv
// alu_pkg: ALUOp/funct constants, control-code and state enums, and the ALU-control decode (DIVU/REMU legal only with ALU_UNIT_DIV_EN)
package alu_pkg;

    localparam logic [2:0] ALUOP_RTYPE = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_SLT   = 3'b010;
    localparam logic [2:0] ALUOP_ADD   = 3'b011;

    localparam logic [5:0] F_ADD  = 6'b000000;
    localparam logic [5:0] F_SUB  = 6'b000001;
    localparam logic [5:0] F_SLL  = 6'b000010;
    localparam logic [5:0] F_SRL  = 6'b000011;
    localparam logic [5:0] F_SLT  = 6'b000100;
    localparam logic [5:0] F_OR   = 6'b000101;
    localparam logic [5:0] F_XOR  = 6'b000110;
    localparam logic [5:0] F_AND  = 6'b000111;
    localparam logic [5:0] F_MUL  = 6'b001000;
    localparam logic [5:0] F_DIVU = 6'b001001;
    localparam logic [5:0] F_REMU = 6'b001010;

    typedef enum logic [3:0] {
        C_ADD  = 4'b0000,
        C_SUB  = 4'b0001,
        C_AND  = 4'b0010,
        C_OR   = 4'b0011,
        C_XOR  = 4'b0100,
        C_SLL  = 4'b0101,
        C_SRL  = 4'b0110,
        C_SLT  = 4'b0111,
        C_MUL  = 4'b1000,
        C_DIVU = 4'b1001,
        C_REMU = 4'b1010
    } ctrl_e;

    typedef enum logic [1:0] {S_IDLE, S_BUSY_MUL, S_BUSY_DIV, S_HOLD} state_e;

    typedef enum logic [1:0] {M_MUL, M_DIVU, M_REMU} mode_e;

    typedef struct packed {
        ctrl_e code;
        logic  illegal;
    } dec_t;

    // Illegal encodings report C_ADD with the illegal flag set
    function automatic dec_t decode(input logic [2:0] alu_op, input logic [5:0] funct);
        dec_t d;
        d.code    = C_ADD;
        d.illegal = 1'b0;
        case (alu_op)
            ALUOP_RTYPE: begin
                case (funct)
                    F_ADD:   d.code = C_ADD;
                    F_SUB:   d.code = C_SUB;
                    F_SLL:   d.code = C_SLL;
                    F_SRL:   d.code = C_SRL;
                    F_SLT:   d.code = C_SLT;
                    F_OR:    d.code = C_OR;
                    F_XOR:   d.code = C_XOR;
                    F_AND:   d.code = C_AND;
                    F_MUL:   d.code = C_MUL;
`ifdef ALU_UNIT_DIV_EN
                    F_DIVU:  d.code = C_DIVU;
                    F_REMU:  d.code = C_REMU;
`endif
                    default: d.illegal = 1'b1;
                endcase
            end
            ALUOP_SUB: d.code = C_SUB;
            ALUOP_SLT: d.code = C_SLT;
            ALUOP_ADD: d.code = C_ADD;
            default:   d.illegal = 1'b1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: iterative shift-add multiplier, plus restoring divider when ALU_UNIT_DIV_EN is defined
module alu_muldiv_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
`ifdef ALU_UNIT_DIV_EN
    input  mode_e            i_mode,
`endif
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_x, r_y, r_z, w_x, w_y, w_z;
`ifdef ALU_UNIT_DIV_EN
    mode_e            r_mode;
    logic [WIDTH:0]   w_sh, w_tr;
`endif

    // One step: MUL adds the shifted multiplicand per multiplier bit; DIVU/REMU trial-subtract the divisor
    always_comb begin
        w_x = r_x + (r_y[0] ? r_z : '0);
        w_y = r_y >> 1;
        w_z = r_z << 1;
`ifdef ALU_UNIT_DIV_EN
        w_sh = {r_x, r_y[WIDTH-1]};
        w_tr = w_sh - {1'b0, r_z};
        if (r_mode != M_MUL) begin
            w_x = w_tr[WIDTH] ? w_sh[WIDTH-1:0] : w_tr[WIDTH-1:0];
            w_y = {r_y[WIDTH-2:0], !w_tr[WIDTH]};
            w_z = r_z;
        end
`endif
    end

    // The final step's combinational value is the answer, so done is flagged during that step
    assign o_done = r_cnt == CW'(1);
`ifdef ALU_UNIT_DIV_EN
    assign o_result = (r_mode == M_DIVU) ? w_y : w_x;
`else
    assign o_result = w_x;
`endif

    // Capture operands on start, then iterate once per edge until the count expires
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_x   <= '0;
            r_y   <= '0;
            r_z   <= '0;
`ifdef ALU_UNIT_DIV_EN
            r_mode <= M_MUL;
`endif
        end else if (i_start) begin
            r_cnt <= CW'(WIDTH);
            r_x   <= '0;
`ifdef ALU_UNIT_DIV_EN
            r_mode <= i_mode;
            r_y    <= (i_mode == M_MUL) ? i_b : i_a;
            r_z    <= (i_mode == M_MUL) ? i_a : i_b;
`else
            r_y <= i_b;
            r_z <= i_a;
`endif
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
            r_x   <= w_x;
            r_y   <= w_y;
            r_z   <= w_z;
        end
    end

endmodule

// File: rtl/alu_unit.sv
// alu_unit: execute-stage ALU with registered result, valid/ready handshake and multi-cycle MUL (DIVU/REMU with ALU_UNIT_DIV_EN)
module alu_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [2:0]       i_alu_op,
    input  logic [5:0]       i_funct,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_result,
    output logic             o_zero,
    output logic             o_illegal
);

    localparam int SH = $clog2(WIDTH);

    state_e           r_state, w_state_nxt;
    dec_t             w_dec;
    logic [WIDTH-1:0] r_result, w_single, w_md_result;
    logic             r_zero, r_illegal;
    logic             w_accept, w_multi, w_is_div, w_start, w_done, w_busy;
`ifdef ALU_UNIT_DIV_EN
    mode_e            w_mode;
`endif

    assign w_dec       = decode(i_alu_op, i_funct);
    assign o_in_ready  = !rst & (r_state == S_IDLE | (r_state == S_HOLD & i_out_ready));
    assign w_accept    = i_in_valid & o_in_ready;
    assign w_is_div    = (w_dec.code == C_DIVU) | (w_dec.code == C_REMU);
    assign w_multi     = !w_dec.illegal & ((w_dec.code == C_MUL) | (w_is_div & (i_b != '0)));
    assign w_start     = w_accept & w_multi;
    assign w_busy      = (r_state == S_BUSY_MUL) | (r_state == S_BUSY_DIV);
    assign o_out_valid = r_state == S_HOLD;
    assign o_result    = r_result;
    assign o_zero      = r_zero;
    assign o_illegal   = r_illegal;
`ifdef ALU_UNIT_DIV_EN
    assign w_mode = (w_dec.code == C_MUL) ? M_MUL : (w_dec.code == C_DIVU) ? M_DIVU : M_REMU;
`endif

    // Single-cycle datapath; divide-by-zero resolves here, illegal ops force a zero result
    always_comb begin
        w_single = '0;
        case (w_dec.code)
            C_ADD:   w_single = i_a + i_b;
            C_SUB:   w_single = i_a - i_b;
            C_AND:   w_single = i_a & i_b;
            C_OR:    w_single = i_a | i_b;
            C_XOR:   w_single = i_a ^ i_b;
            C_SLL:   w_single = i_a << i_b[SH-1:0];
            C_SRL:   w_single = i_a >> i_b[SH-1:0];
            C_SLT:   w_single = {{(WIDTH-1){1'b0}}, $signed(i_a) < $signed(i_b)};
            C_DIVU:  w_single = '1;
            C_REMU:  w_single = i_a;
            default: w_single = '0;
        endcase
        if (w_dec.illegal) w_single = '0;
    end

    alu_muldiv_seq #(.WIDTH(WIDTH)) u_seq (
        .clk      (clk),
        .rst      (rst),
        .i_start  (w_start),
`ifdef ALU_UNIT_DIV_EN
        .i_mode   (w_mode),
`endif
        .i_a      (i_a),
        .i_b      (i_b),
        .o_done   (w_done),
        .o_result (w_md_result)
    );

    // Next state: accept wins, otherwise drain HOLD or finish an iteration run
    always_comb begin
        w_state_nxt = r_state;
        if (w_accept) w_state_nxt = !w_multi ? S_HOLD : (w_dec.code == C_MUL) ? S_BUSY_MUL : S_BUSY_DIV;
        else if (r_state == S_HOLD && i_out_ready) w_state_nxt = S_IDLE;
        else if (w_busy && w_done) w_state_nxt = S_HOLD;
    end

    // State and output registers, loaded on a single-cycle accept or on the last iteration
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_result  <= '0;
            r_zero    <= 1'b1;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept && !w_multi) begin
                r_result  <= w_single;
                r_zero    <= w_single == '0;
                r_illegal <= w_dec.illegal;
            end else if (w_busy && w_done) begin
                r_result  <= w_md_result;
                r_zero    <= w_md_result == '0;
                r_illegal <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_unit.sv
// tb_alu_unit: directed and randomized checks of alu_unit against an arithmetic reference model
module tb_alu_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_in_valid;
    logic        o_in_ready;
    logic [2:0]  i_alu_op;
    logic [5:0]  i_funct;
    logic [31:0] i_a;
    logic [31:0] i_b;
    logic        o_out_valid;
    logic        i_out_ready;
    logic [31:0] o_result;
    logic        o_zero;
    logic        o_illegal;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    bit          m_valid = 1'b0;
    bit          m_ill   = 1'b0;
    logic [31:0] m_res   = '0;
    int          m_left  = 0;

    alu_unit #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_in_valid  (i_in_valid),
        .o_in_ready  (o_in_ready),
        .i_alu_op    (i_alu_op),
        .i_funct     (i_funct),
        .i_a         (i_a),
        .i_b         (i_b),
        .o_out_valid (o_out_valid),
        .i_out_ready (i_out_ready),
        .o_result    (o_result),
        .o_zero      (o_zero),
        .o_illegal   (o_illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Reference: what an op must produce and how many edges it takes beyond the accept edge
    function automatic void ref_op(input logic [2:0] op, input logic [5:0] f, input logic [31:0] a,
                                   input logic [31:0] b, output logic [31:0] r, output bit ill, output int lat);
        logic [4:0] s;
        s   = b[4:0];
        r   = '0;
        ill = 1'b0;
        lat = 0;
        case (op)
            3'd0: begin
                case (f)
                    6'd0: r = a + b;
                    6'd1: r = a - b;
                    6'd2: r = a << s;
                    6'd3: r = a >> s;
                    6'd4: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    6'd5: r = a | b;
                    6'd6: r = a ^ b;
                    6'd7: r = a & b;
                    6'd8: begin r = a * b; lat = 32; end
`ifdef ALU_UNIT_DIV_EN
                    6'd9: begin
                        if (b == 0) r = 32'hFFFF_FFFF;
                        else begin r = a / b; lat = 32; end
                    end
                    6'd10: begin
                        if (b == 0) r = a;
                        else begin r = a % b; lat = 32; end
                    end
`endif
                    default: ill = 1'b1;
                endcase
            end
            3'd1: r = a - b;
            3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: r = a + b;
            default: ill = 1'b1;
        endcase
    endfunction

    // Model: one result slot that is either counting down or held until taken
    initial begin
        forever begin
            logic [31:0] r;
            bit          ill;
            int          lat;
            bit          rdy;
            @(posedge clk);
            if (rst) begin
                m_valid = 1'b0;
                m_left  = 0;
            end else begin
                rdy = (m_left == 0) && (!m_valid || i_out_ready);
                if (m_left > 0) begin
                    m_left--;
                    m_valid = (m_left == 0);
                end else if (m_valid && i_out_ready) m_valid = 1'b0;
                if (i_in_valid && rdy) begin
                    ref_op(i_alu_op, i_funct, i_a, i_b, r, ill, lat);
                    m_res   = r;
                    m_ill   = ill;
                    m_left  = lat;
                    m_valid = (lat == 0);
                end
            end
        end
    end

    // Every mid-cycle: handshake and held result must agree with the model
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("in_ready", {31'd0, o_in_ready}, {31'd0, !rst && m_left == 0 && (!m_valid || i_out_ready)});
                check("out_valid", {31'd0, o_out_valid}, {31'd0, m_valid});
                if (m_valid) begin
                    check("result", o_result, m_res);
                    check("zero", {31'd0, o_zero}, {31'd0, m_res == 0});
                    check("illegal", {31'd0, o_illegal}, {31'd0, m_ill});
                end
            end
        end
    end

    task automatic send(input logic [2:0] op, input logic [5:0] f, input logic [31:0] av,
                        input logic [31:0] bv, output int waits);
        bit rdy;
        i_in_valid = 1'b1;
        i_alu_op   = op;
        i_funct    = f;
        i_a        = av;
        i_b        = bv;
        for (waits = 0; waits < 200; waits++) begin
            @(negedge clk);
            rdy = o_in_ready;
            @(posedge clk);
            #1;
            if (rdy) break;
        end
        if (waits == 200) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: got no accept within 200 cycles, want accept");
        end
        i_in_valid = 1'b0;
        i_a        = $urandom;
        i_b        = $urandom;
    endtask

    task automatic wait_out(output int cyc, output int bad);
        @(negedge clk);
        cyc = 0;
        bad = 0;
        while (!o_out_valid && cyc < 100) begin
            if (o_in_ready) bad++;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic realign();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int w, cyc, bad;
        rst         = 1'b1;
        i_in_valid  = 1'b0;
        i_out_ready = 1'b1;
        i_alu_op    = '0;
        i_funct     = '0;
        i_a         = '0;
        i_b         = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_in_ready", {31'd0, o_in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, o_out_valid}, 32'd0);
        check("rst_result", o_result, 32'd0);
        check("rst_zero", {31'd0, o_zero}, 32'd1);
        check("rst_illegal", {31'd0, o_illegal}, 32'd0);
        realign();
        rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", {31'd0, o_in_ready}, 32'd1);
        check("idle_out_valid", {31'd0, o_out_valid}, 32'd0);
        realign();

        send(3'd0, 6'd1, 32'd5, 32'd7, w);
        wait_out(cyc, bad);
        check("sub_lat", cyc, 32'd0);
        check("sub_result", o_result, 32'hFFFF_FFFE);
        check("sub_zero", {31'd0, o_zero}, 32'd0);
        realign();
        send(3'd0, 6'd4, 32'd5, 32'd7, w);
        wait_out(cyc, bad);
        check("slt_result", o_result, 32'd1);
        realign();
        send(3'd2, 6'd0, 32'hFFFF_FFFF, 32'd1, w);
        wait_out(cyc, bad);
        check("slti_neg_result", o_result, 32'd1);
        realign();
        send(3'd0, 6'd2, 32'h0000_0003, 32'h0000_0024, w);
        wait_out(cyc, bad);
        check("sll_result", o_result, 32'h0000_0030);
        realign();
        send(3'd5, 6'd0, 32'd9, 32'd9, w);
        wait_out(cyc, bad);
        check("badop_illegal", {31'd0, o_illegal}, 32'd1);
        check("badop_result", o_result, 32'd0);
        realign();

        send(3'd0, 6'd8, 32'h0001_0000, 32'h0001_0001, w);
        wait_out(cyc, bad);
        check("mul_lat", cyc, 32'd32);
        check("mul_in_ready_busy", bad, 32'd0);
        check("mul_result", o_result, 32'h0001_0000);
        realign();

`ifdef ALU_UNIT_DIV_EN
        send(3'd0, 6'd9, 32'd100, 32'd7, w);
        wait_out(cyc, bad);
        check("divu_lat", cyc, 32'd32);
        check("divu_result", o_result, 32'd14);
        realign();
        send(3'd0, 6'd10, 32'd100, 32'd7, w);
        wait_out(cyc, bad);
        check("remu_lat", cyc, 32'd32);
        check("remu_result", o_result, 32'd2);
        realign();
        send(3'd0, 6'd9, 32'd100, 32'd0, w);
        wait_out(cyc, bad);
        check("div0_lat", cyc, 32'd0);
        check("div0_result", o_result, 32'hFFFF_FFFF);
        realign();
        send(3'd0, 6'd10, 32'd100, 32'd0, w);
        wait_out(cyc, bad);
        check("rem0_result", o_result, 32'd100);
        realign();
`else
        send(3'd0, 6'd9, 32'd100, 32'd7, w);
        wait_out(cyc, bad);
        check("divu_off_lat", cyc, 32'd0);
        check("divu_off_illegal", {31'd0, o_illegal}, 32'd1);
        check("divu_off_result", o_result, 32'd0);
        realign();
`endif

        i_out_ready = 1'b0;
        send(3'd3, 6'd0, 32'd3, 32'd4, w);
        repeat (5) begin
            @(negedge clk);
            check("bp_valid", {31'd0, o_out_valid}, 32'd1);
            check("bp_result", o_result, 32'd7);
            check("bp_in_ready", {31'd0, o_in_ready}, 32'd0);
        end
        realign();
        i_out_ready = 1'b1;
        send(3'd3, 6'd0, 32'd10, 32'd20, w);
        check("b2b_waits", w, 32'd0);
        wait_out(cyc, bad);
        check("b2b_lat", cyc, 32'd0);
        check("b2b_result", o_result, 32'd30);
        realign();

        send(3'd0, 6'd8, 32'h1234, 32'h5678, w);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        realign();
        rst = 1'b0;
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (o_out_valid) bad++;
        end
        check("abort_no_valid", bad, 32'd0);
        realign();
        send(3'd3, 6'd0, 32'd3, 32'd4, w);
        wait_out(cyc, bad);
        check("post_abort_lat", cyc, 32'd0);
        check("post_abort_result", o_result, 32'd7);
        realign();

        for (int i = 0; i < 3000; i++) begin
            i_in_valid  = 1'($urandom_range(0, 1));
            i_out_ready = $urandom_range(0, 3) != 0;
            i_alu_op    = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
            i_funct     = ($urandom_range(0, 9) == 0) ? 6'($urandom) : 6'($urandom_range(0, 10));
            i_a         = $urandom;
            case ($urandom_range(0, 3))
                0:       i_b = '0;
                1:       i_b = 32'($urandom_range(1, 40));
                default: i_b = $urandom;
            endcase
            realign();
        end
        i_in_valid  = 1'b0;
        i_out_ready = 1'b1;
        repeat (40) realign();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_unit.md
# alu_unit

Parametrised execute-stage ALU for the MIPS datapath. It merges ALU-control decode (ALUOp + funct) with a registered result stage and adds iterative multi-cycle MUL/DIVU/REMU behind a valid/ready handshake. It sits between the ID/EX register and the EX/MEM register, and stalls the pipeline through `in_ready` while a multi-cycle operation runs.

## Interface
- `WIDTH`, 32: operand/result width; power of two, ≥8
- `clk`  input  1  rising-edge clock
- `rst`  input  1  synchronous, active-high reset
- `in_valid`  input  1  operation presented
- `in_ready`  output  1  operation accepted this edge when `in_valid & in_ready`
- `alu_op`  input  3  class: 000 R-type (use funct), 001 SUB (branch), 010 SLT (slti), 011 ADD (lw/sw/addi), others illegal
- `funct`  input  6  R-type function
- `a`, `b`  input  WIDTH  operands (rs, rt/imm)
- `out_valid`  output  1  result held valid
- `out_ready`  input  1  consumer takes result
- `result`  output  WIDTH  registered result
- `zero`  output  1  `result == 0` (registered)
- `illegal`  output  1  undefined op/funct; qualified by `out_valid`

## Operation
- Control codes: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLL, 0110 SRL, 0111 SLT (signed), 1000 MUL (low WIDTH bits), 1001 DIVU (quotient), 1010 REMU.
- R-type funct map: 000000→ADD, 000001→SUB, 000010→SLL, 000011→SRL, 000100→SLT, 000101→OR, 000110→XOR, 000111→AND, 001000→MUL, 001001→DIVU, 001010→REMU; others illegal.
- Shift amount is `b[log2(WIDTH)-1:0]`; `a` is shifted. ADD/SUB wrap modulo 2^WIDTH with no overflow trap.
- States: IDLE, BUSY_MUL, BUSY_DIV, HOLD.
- `in_ready = !rst & (state==IDLE | (state==HOLD & out_ready))`.
- Single-cycle op, or illegal op, on accept: result, zero and illegal are registered; state goes to HOLD. An illegal op gives result 0 and `illegal`=1.
- MUL accept: goes to BUSY_MUL with count=WIDTH. Shift-add runs one bit per edge. At the last step, result is loaded and state goes to HOLD.
- DIVU/REMU accept: goes to BUSY_DIV with count=WIDTH. Restoring division runs one bit per edge.
- Divide by zero is detected at accept. It completes as a single-cycle op with quotient all ones and remainder = `a`.
- HOLD: `out_valid`=1 and outputs are stable until `out_ready`. When `out_ready` is high and no new accept occurs, state returns to IDLE with `out_valid`=0. When `out_ready` is high and a new op is accepted on the same edge, the next op starts back-to-back.
- Operands are captured at accept; later changes to `a`/`b` do not affect an in-flight op.

## Timing
- Reset values: `out_valid`=0, `result`=0, `zero`=1, `illegal`=0, state=IDLE, count=0. `in_ready`=0 while `rst` is high.
- Single-cycle latency: accept at edge N → `out_valid` high after edge N.
- MUL/DIVU/REMU latency: accept at edge N → iterations on edges N+1…N+WIDTH → `out_valid` high after edge N+WIDTH.
- Throughput: one single-cycle op per clock while `out_ready` stays high.
- `rst` mid-operation aborts the op. No result is produced and state is IDLE after the reset edge.
- `out_ready` has no effect while `out_valid`=0. `in_valid` has no effect while `in_ready`=0.

## Configuration
- `ALU_UNIT_DIV_EN`: defined → divider datapath and BUSY_DIV are built.
- Undefined → funct 001001/001010 decode as illegal, complete in one cycle with result 0 and `illegal`=1, and no divider logic exists.
- MUL is always present.

## Structure
- Package `alu_pkg`:
  - ALUOp constants
  - funct constants
  - 4-bit control-code enum
  - state enum
  - `decode(alu_op, funct)` function returning code and illegal flag
- Sub-module `alu_muldiv_seq`: iterative engine with start/done, operands, mode (mul/divu/remu) and WIDTH-bit result. `alu_unit` holds decode, single-cycle datapath, handshake and output register.

## Test plan
- Reset then idle: `out_valid`=0, `result`=0, `zero`=1, `in_ready`=1 after reset release.
- alu_op=000, funct=000001, a=5, b=7 → next cycle `result`=0xFFFFFFFE, `zero`=0. With funct=000100, same operands → `result`=1.
- MUL a=0x10000, b=0x10001 → `out_valid` exactly 32 cycles after accept, `result`=0x00010000. `in_ready`=0 throughout.
- DIVU a=100, b=7 → 14 after 32 cycles; REMU gives 2. DIVU with b=0 → 0xFFFFFFFF after 1 cycle. Without `ALU_UNIT_DIV_EN` → `illegal`=1, `result`=0.
- Backpressure: hold `out_ready`=0 for 5 cycles → result stable and `in_ready`=0. Raise `out_ready` with a new op valid → back-to-back accept on that edge.
- Assert `rst` at iteration 10 of a MUL → `out_valid` never rises for it; the next ADD 3+4 returns 7 in 1 cycle.
